// File: rtl/mult_operand_gate_if.sv
// Handshake and operand bus between the operand-gating stage, its upstream
// source and the downstream multiplier.
interface mult_operand_gate_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic             zero_flag;
    logic             reuse_flag;
    logic             gate_en;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, mult_a, mult_b, zero_flag, reuse_flag, gate_en
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, mult_a, mult_b, zero_flag, reuse_flag, gate_en
    );
endinterface

// File: rtl/mult_operand_gate.sv
// Operand gating stage for an approximate multiplier: skips operand-register
// updates for zero operands and repeated operand pairs, with usage statistics.
module mult_operand_gate #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    mult_operand_gate_if.slave  bus,
    input  logic                stat_clr,
    output logic [CNT_W-1:0]    stat_issued,
    output logic [CNT_W-1:0]    stat_gated
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             out_valid_w;
    logic             in_ready_w;
    logic             accept;
    logic             cls_zero;
    logic             cls_reuse;
    logic             cls_normal;
    logic [WIDTH-1:0] mult_a_q;
    logic [WIDTH-1:0] mult_b_q;
    logic             ops_valid_q;
    logic             zero_flag_q;
    logic             reuse_flag_q;
    logic [1:0]       cnt_inc;

    // ---------------------------------------------------------------
    // Control FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Control FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Control FSM: outputs. in_ready is forced low during reset so nothing
    // can be accepted while the stage is being cleared.
    always_comb begin
        out_valid_w = (state_q == FULL);
        in_ready_w  = !rst && (!out_valid_w || bus.out_ready);
    end

    assign accept = bus.in_valid && in_ready_w;

    // ---------------------------------------------------------------
    // Operand classification; ZERO wins over REUSE
    // ---------------------------------------------------------------
    always_comb begin
        cls_zero   = (bus.in_a == '0) || (bus.in_b == '0);
        cls_reuse  = !cls_zero && ops_valid_q &&
                     (bus.in_a == mult_a_q) && (bus.in_b == mult_b_q);
        cls_normal = !cls_zero && !cls_reuse;
    end

    // Operand registers only see a clock enable for a real multiply
    assign bus.gate_en = accept && cls_normal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            ops_valid_q <= 1'b0;
        end else if (bus.gate_en) begin
            mult_a_q    <= bus.in_a;
            mult_b_q    <= bus.in_b;
            ops_valid_q <= 1'b1;
        end
    end

    // Flags describe the pending op; they only change when a new op is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_flag_q  <= 1'b0;
            reuse_flag_q <= 1'b0;
        end else if (accept) begin
            zero_flag_q  <= cls_zero;
            reuse_flag_q <= cls_reuse;
        end
    end

    // ---------------------------------------------------------------
    // Saturating statistics counters: [0] issued, [1] gated
    // ---------------------------------------------------------------
    assign cnt_inc[0] = accept;
    assign cnt_inc[1] = accept && !cls_normal;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Clear beats a coincident increment; all-ones is sticky
            always_comb begin
                cnt_d = cnt_q;
                if (stat_clr) begin
                    cnt_d = '0;
                end else if (cnt_inc[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign stat_issued = g_cnt[0].cnt_q;
    assign stat_gated  = g_cnt[1].cnt_q;

    // ---------------------------------------------------------------
    // Output drive
    // ---------------------------------------------------------------
    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.zero_flag  = zero_flag_q;
    assign bus.reuse_flag = reuse_flag_q;

endmodule

// File: tb/tb_mult_operand_gate.sv
// Self-checking bench for mult_operand_gate: per-cycle comparison against a
// behavioural model plus directed scenarios with literal expectations.
module tb_mult_operand_gate;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             stat_clr;
    logic [CNT_W-1:0] stat_issued;
    logic [CNT_W-1:0] stat_gated;

    int tests_run = 0;
    int tests_failed = 0;

    mult_operand_gate_if #(.WIDTH(WIDTH)) bus ();

    mult_operand_gate #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .stat_clr    (stat_clr),
        .stat_issued (stat_issued),
        .stat_gated  (stat_gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model of what the stage holds: the pending op (if any), the operand pair
    // last sent to the multiplier, and the two event counts.
    int m_pending;      // 0/1: an op is waiting for downstream
    int m_have_ops;     // multiplier has ever been loaded since reset
    int m_a, m_b;       // operands currently at the multiplier
    int m_zero, m_reuse;
    int m_issued, m_gated;

    // 0 = NORMAL, 1 = ZERO, 2 = REUSE
    function automatic int op_class(input int a, input int b);
        if (a == 0 || b == 0) return 1;
        if (m_have_ops != 0 && a == m_a && b == m_b) return 2;
        return 0;
    endfunction

    function automatic int can_take();
        return (rst == 1'b0 && (m_pending == 0 || bus.out_ready == 1'b1)) ? 1 : 0;
    endfunction

    function automatic int takes_op();
        return (bus.in_valid == 1'b1 && can_take() != 0) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending  <= 0;
            m_have_ops <= 0;
            m_a        <= 0;
            m_b        <= 0;
            m_zero     <= 0;
            m_reuse    <= 0;
            m_issued   <= 0;
            m_gated    <= 0;
        end else begin
            if (takes_op() != 0) begin
                m_pending <= 1;
                m_zero    <= (op_class(int'(bus.in_a), int'(bus.in_b)) == 1) ? 1 : 0;
                m_reuse   <= (op_class(int'(bus.in_a), int'(bus.in_b)) == 2) ? 1 : 0;
                if (op_class(int'(bus.in_a), int'(bus.in_b)) == 0) begin
                    m_a        <= int'(bus.in_a);
                    m_b        <= int'(bus.in_b);
                    m_have_ops <= 1;
                end
            end else if (bus.out_ready) begin
                m_pending <= 0;
            end
            if (stat_clr) begin
                m_issued <= 0;
                m_gated  <= 0;
            end else if (takes_op() != 0) begin
                m_issued <= (m_issued + 1 > CNT_MAX) ? CNT_MAX : m_issued + 1;
                if (op_class(int'(bus.in_a), int'(bus.in_b)) != 0)
                    m_gated <= (m_gated + 1 > CNT_MAX) ? CNT_MAX : m_gated + 1;
            end
        end
    end

    // Per-cycle comparison away from the active edge
    always @(negedge clk) begin
        chk("cyc in_ready", bus.in_ready, can_take());
        chk("cyc out_valid", bus.out_valid, m_pending);
        chk("cyc gate_en", bus.gate_en,
            (takes_op() != 0 && op_class(int'(bus.in_a), int'(bus.in_b)) == 0) ? 1 : 0);
        chk("cyc mult_a", bus.mult_a, m_a);
        chk("cyc mult_b", bus.mult_b, m_b);
        chk("cyc stat_issued", stat_issued, m_issued);
        chk("cyc stat_gated", stat_gated, m_gated);
        if (m_pending != 0) begin
            chk("cyc zero_flag", bus.zero_flag, m_zero);
            chk("cyc reuse_flag", bus.reuse_flag, m_reuse);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair, check the combinational gate enable, clock it in
    task automatic send(input int a, input int b, input int exp_gate);
        bus.in_valid = 1'b1;
        bus.in_a     = WIDTH'(a);
        bus.in_b     = WIDTH'(b);
        #1;
        chk("send gate_en", bus.gate_en, exp_gate);
        tick();
        bus.in_valid = 1'b0;
        $display("[TB] op (%0d,%0d): mult=%0d/%0d zero=%0d reuse=%0d issued=%0d gated=%0d",
                 a, b, bus.mult_a, bus.mult_b, bus.zero_flag, bus.reuse_flag,
                 stat_issued, stat_gated);
    endtask

    task automatic chk_out(input string tag, input int a, input int b, input int zf,
                           input int rf, input int iss, input int gat);
        chk({tag, " out_valid"}, bus.out_valid, 1);
        chk({tag, " mult_a"}, bus.mult_a, a);
        chk({tag, " mult_b"}, bus.mult_b, b);
        chk({tag, " zero_flag"}, bus.zero_flag, zf);
        chk({tag, " reuse_flag"}, bus.reuse_flag, rf);
        chk({tag, " stat_issued"}, stat_issued, iss);
        chk({tag, " stat_gated"}, stat_gated, gat);
    endtask

    initial begin
        rst           = 1'b0;
        stat_clr      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst gate_en", bus.gate_en, 0);
        chk("rst mult_a", bus.mult_a, 0);
        chk("rst stat_issued", stat_issued, 0);
        rst = 1'b0;
        tick();

        // First normal op, then a repeat of it
        send(3, 5, 1);
        chk_out("normal", 3, 5, 0, 0, 1, 0);
        send(3, 5, 0);
        chk_out("reuse", 3, 5, 0, 1, 2, 1);

        // Zero operand leaves the multiplier operands untouched
        send(0, 9, 0);
        chk_out("zero", 3, 5, 1, 0, 3, 2);
        send(3, 5, 0);
        chk_out("reuse2", 3, 5, 0, 1, 4, 3);

        // Downstream stall with a second pair waiting
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'd7;
        bus.in_b      = 8'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall in_ready", bus.in_ready, 0);
            chk("stall gate_en", bus.gate_en, 0);
            tick();
            chk_out("stall", 3, 5, 0, 1, 4, 3);
        end
        bus.out_ready = 1'b1;
        send(7, 2, 1);
        chk_out("handoff", 7, 2, 0, 0, 5, 3);

        // Extreme operands and zero in the B position
        send(255, 255, 1);
        chk_out("max", 255, 255, 0, 0, 6, 3);
        send(1, 0, 0);
        chk_out("zero_b", 255, 255, 1, 0, 7, 4);
        tick();
        chk("drain out_valid", bus.out_valid, 0);

        // Reset pulsed mid-operation
        send(9, 9, 1);
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", bus.out_valid, 0);
        chk("async in_ready", bus.in_ready, 0);
        chk("async mult_a", bus.mult_a, 0);
        chk("async stat_issued", stat_issued, 0);
        tick();
        rst = 1'b0;
        tick();
        send(3, 5, 1);
        chk_out("post_rst", 3, 5, 0, 0, 1, 0);

        // Counter saturation and clear priority
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr stat_issued", stat_issued, 0);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd0;
        bus.in_b     = 8'd1;
        repeat (CNT_MAX - 1) tick();
        chk("pre_sat stat_issued", stat_issued, CNT_MAX - 1);
        chk("pre_sat stat_gated", stat_gated, CNT_MAX - 1);
        tick();
        chk("sat1 stat_issued", stat_issued, CNT_MAX);
        chk("sat1 stat_gated", stat_gated, CNT_MAX);
        tick();
        chk("sat2 stat_issued", stat_issued, CNT_MAX);
        chk("sat2 stat_gated", stat_gated, CNT_MAX);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_acc stat_issued", stat_issued, 0);
        chk("clr_acc stat_gated", stat_gated, 0);
        $display("[TB] saturation/clear sequence done: issued=%0d gated=%0d",
                 stat_issued, stat_gated);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
